// File: rtl/maze_pkg.sv
// Shared maze constants, wall bit layout, move direction and controller state types.
package maze_pkg;

    localparam int unsigned MAZE_ROWS = 15;
    localparam int unsigned MAZE_COLS = 15;

    localparam int unsigned WALL_N = 3;
    localparam int unsigned WALL_E = 2;
    localparam int unsigned WALL_S = 1;
    localparam int unsigned WALL_W = 0;

    typedef enum logic [1:0] {
        DirN,
        DirE,
        DirS,
        DirW
    } dir_e;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRead,
        StCheck,
        StCool,
        StWon
    } state_e;

    function automatic logic wall_set(input logic [3:0] walls, input dir_e dir);
        logic res;
        case (dir)
            DirN:    res = walls[WALL_N];
            DirE:    res = walls[WALL_E];
            DirS:    res = walls[WALL_S];
            default: res = walls[WALL_W];
        endcase
        return res;
    endfunction

endpackage

// File: rtl/player_move_ctrl_if.sv
// Request/grant port to the shared maze wall memory.
interface player_move_ctrl_if;

    logic       mem_req;
    logic       mem_gnt;
    logic [3:0] mem_row;
    logic [3:0] mem_col;
    logic [3:0] mem_walls;

    modport master (
        output mem_req,
        output mem_row,
        output mem_col,
        input  mem_gnt,
        input  mem_walls
    );

    modport slave (
        input  mem_req,
        input  mem_row,
        input  mem_col,
        output mem_gnt,
        output mem_walls
    );

endinterface

// File: rtl/player_move_ctrl.sv
// One-move-per-pulse player controller: fetches the current cell's walls, then moves or blocks.
// Define MAZE_MOVE_COUNT_EN to add the saturating move_count output.
module player_move_ctrl
    import maze_pkg::*;
#(
    parameter int unsigned START_ROW   = 0,
    parameter int unsigned START_COL   = 0,
    parameter int unsigned GOAL_ROW    = 14,
    parameter int unsigned GOAL_COL    = 14,
    parameter int unsigned COOL_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               restart,
    player_move_ctrl_if.master mem,
    output logic [3:0]         player_row,
    output logic [3:0]         player_col,
    output logic               moved,
    output logic               blocked,
    output logic               win,
    output logic               busy
`ifdef MAZE_MOVE_COUNT_EN
    ,
    output logic [9:0]         move_count
`endif
);

    localparam int unsigned CntW = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;

    localparam logic [3:0] StartRow = 4'(START_ROW);
    localparam logic [3:0] StartCol = 4'(START_COL);
    localparam logic [3:0] GoalRow  = 4'(GOAL_ROW);
    localparam logic [3:0] GoalCol  = 4'(GOAL_COL);
    localparam logic [3:0] LastRow  = 4'(MAZE_ROWS - 1);
    localparam logic [3:0] LastCol  = 4'(MAZE_COLS - 1);
    localparam logic [CntW-1:0] CoolLoad = CntW'(COOL_CYCLES - 1);

    state_e          state_q, state_d;
    dir_e            dir_q, dir_d;
    logic [3:0]      walls_q, walls_d;
    logic [3:0]      row_q, row_d;
    logic [3:0]      col_q, col_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            moved_q, moved_d;
    logic            blocked_q, blocked_d;
    logic            win_q, win_d;

    logic [3:0]      tgt_row, tgt_col;
    logic            out_of_bounds;
    logic            any_btn;

    assign any_btn = btn_up | btn_down | btn_left | btn_right;

    always_comb begin
        tgt_row       = row_q;
        tgt_col       = col_q;
        out_of_bounds = 1'b0;
        case (dir_q)
            DirN: begin
                out_of_bounds = (row_q == 4'd0);
                tgt_row       = row_q - 4'd1;
            end
            DirS: begin
                out_of_bounds = (row_q >= LastRow);
                tgt_row       = row_q + 4'd1;
            end
            DirW: begin
                out_of_bounds = (col_q == 4'd0);
                tgt_col       = col_q - 4'd1;
            end
            default: begin
                out_of_bounds = (col_q >= LastCol);
                tgt_col       = col_q + 4'd1;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        walls_d   = walls_q;
        row_d     = row_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        moved_d   = 1'b0;
        blocked_d = 1'b0;
        win_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (any_btn) begin
                    if (btn_up)        dir_d = DirN;
                    else if (btn_down) dir_d = DirS;
                    else if (btn_left) dir_d = DirW;
                    else               dir_d = DirE;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (mem.mem_gnt) state_d = StRead;
            end
            StRead: begin
                walls_d = mem.mem_walls;
                state_d = StCheck;
            end
            StCheck: begin
                if (out_of_bounds || wall_set(walls_q, dir_q)) begin
                    blocked_d = 1'b1;
                end else begin
                    moved_d = 1'b1;
                    row_d   = tgt_row;
                    col_d   = tgt_col;
                end
                if (row_d == GoalRow && col_d == GoalCol) begin
                    win_d   = 1'b1;
                    state_d = StWon;
                end else begin
                    cnt_d   = CoolLoad;
                    state_d = StCool;
                end
            end
            StCool: begin
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StWon: ;
            default: state_d = StIdle;
        endcase

        // Restart wins over any grant or button seen in the same cycle.
        if (restart) begin
            state_d   = StIdle;
            dir_d     = DirN;
            row_d     = StartRow;
            col_d     = StartCol;
            cnt_d     = '0;
            moved_d   = 1'b0;
            blocked_d = 1'b0;
            win_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            dir_q     <= DirN;
            walls_q   <= '0;
            row_q     <= StartRow;
            col_q     <= StartCol;
            cnt_q     <= '0;
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
            win_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            walls_q   <= walls_d;
            row_q     <= row_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            moved_q   <= moved_d;
            blocked_q <= blocked_d;
            win_q     <= win_d;
        end
    end

    // mem_req decodes straight from state so an async reset drops it at once.
    assign mem.mem_req = (state_q == StReq);
    assign mem.mem_row = row_q;
    assign mem.mem_col = col_q;

    assign player_row = row_q;
    assign player_col = col_q;
    assign moved      = moved_q;
    assign blocked    = blocked_q;
    assign win        = win_q;
    assign busy       = (state_q != StIdle);

`ifdef MAZE_MOVE_COUNT_EN
    logic [9:0] move_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_cnt_q <= '0;
        end else if (restart) begin
            move_cnt_q <= '0;
        end else if (moved_d && move_cnt_q != 10'h3FF) begin
            move_cnt_q <= move_cnt_q + 10'd1;
        end
    end

    assign move_count = move_cnt_q;
`endif

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl: single moves, bounds, priority, grant stall, win, resets.
module tb_player_move_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       restart;
    logic [3:0] player_row, player_col;
    logic       moved, blocked, win, busy;
`ifdef MAZE_MOVE_COUNT_EN
    logic [9:0] move_count;
`endif

    int n_tests;
    int n_fail;
    int cur_row;
    int cur_col;

    player_move_ctrl_if mem_bus ();

    player_move_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .restart    (restart),
        .mem        (mem_bus),
        .player_row (player_row),
        .player_col (player_col),
        .moved      (moved),
        .blocked    (blocked),
        .win        (win),
        .busy       (busy)
`ifdef MAZE_MOVE_COUNT_EN
        ,
        .move_count (move_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // btns = {up, down, left, right}; exp_busy < 0 means the move ends in WON.
    task automatic do_move(input string tag, input logic [3:0] btns, input logic [3:0] walls,
                           input int gnt_wait, input logic exp_moved, input int exp_row,
                           input int exp_col, input logic exp_win, input int exp_busy);
        logic [3:0] r0, c0;
        int         busy_cnt;
        int         k;
        r0 = player_row;
        c0 = player_col;
        {btn_up, btn_down, btn_left, btn_right} = btns;
        @(negedge clk);
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        check_eq({tag, ".req"}, 32'(mem_bus.mem_req), 1);
        check_eq({tag, ".addr"}, {mem_bus.mem_row, mem_bus.mem_col}, {r0, c0});
        for (int i = 0; i < gnt_wait; i++) begin
            btn_up = 1'b1;
            @(negedge clk);
            btn_up = 1'b0;
            check_eq({tag, ".hold_req"}, 32'(mem_bus.mem_req), 1);
            check_eq({tag, ".hold_addr"}, {mem_bus.mem_row, mem_bus.mem_col}, {r0, c0});
        end
        mem_bus.mem_gnt = 1'b1;
        @(negedge clk);
        mem_bus.mem_gnt   = 1'b0;
        mem_bus.mem_walls = walls;
        check_eq({tag, ".req_drop"}, 32'(mem_bus.mem_req), 0);
        @(negedge clk);
        mem_bus.mem_walls = 4'hF;
        check_eq({tag, ".early"}, 32'({moved, blocked}), 0);
        @(negedge clk);
        check_eq({tag, ".moved"}, 32'(moved), 32'(exp_moved));
        check_eq({tag, ".blocked"}, 32'(blocked), 32'(!exp_moved));
        check_eq({tag, ".row"}, 32'(player_row), exp_row);
        check_eq({tag, ".col"}, 32'(player_col), exp_col);
        check_eq({tag, ".win"}, 32'(win), 32'(exp_win));
        if (exp_busy >= 0) begin
            busy_cnt = 3 + gnt_wait;
            k = 0;
            while (busy && k < 40) begin
                busy_cnt++;
                k++;
                @(negedge clk);
            end
            check_eq({tag, ".idle"}, 32'(busy), 0);
            check_eq({tag, ".busy_cycles"}, busy_cnt, exp_busy);
        end
        cur_row = exp_row;
        cur_col = exp_col;
    endtask

    task automatic walk(input logic [3:0] btns, input int n, input int dr, input int dc);
        for (int i = 0; i < n; i++) begin
            do_move("walk", btns, 4'h0, 0, 1'b1, cur_row + dr, cur_col + dc, 1'b0, 19);
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        cur_row = 0;
        cur_col = 0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cur_row = 0;
        cur_col = 0;
        rst_n   = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        restart           = 1'b0;
        mem_bus.mem_gnt   = 1'b0;
        mem_bus.mem_walls = 4'h0;

        repeat (2) @(negedge clk);
        check_eq("rst.row", 32'(player_row), 0);
        check_eq("rst.col", 32'(player_col), 0);
        check_eq("rst.outs", 32'({mem_bus.mem_req, moved, blocked, win, busy}), 0);
        check_eq("rst.addr", 32'({mem_bus.mem_row, mem_bus.mem_col}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // East wall clear, N and W set: move right, then 16-cycle lockout.
        do_move("right", 4'b0001, 4'b1001, 0, 1'b1, 0, 1, 1'b0, 19);

        pulse_restart();
        check_eq("restart.row", 32'(player_row), 0);
        check_eq("restart.col", 32'(player_col), 0);
        check_eq("restart.busy", 32'(busy), 0);

        do_move("up_oob", 4'b1000, 4'b0000, 0, 1'b0, 0, 0, 1'b0, 19);

        walk(4'b0100, 3, 1, 0);
        walk(4'b0001, 3, 0, 1);
        // Down beats left; south wall set.
        do_move("down_left", 4'b0110, 4'b0010, 0, 1'b0, 3, 3, 1'b0, 19);

        // Grant stalled 10 cycles with btn_up pulsed throughout; right must stand.
        do_move("gnt_wait", 4'b0001, 4'b0000, 10, 1'b1, 3, 4, 1'b0, 29);

        walk(4'b0100, 10, 1, 0);
        walk(4'b0001, 10, 0, 1);
        do_move("right_oob", 4'b0001, 4'b0000, 0, 1'b0, 13, 14, 1'b0, 19);
        do_move("win", 4'b0100, 4'b0100, 0, 1'b1, 14, 14, 1'b1, -1);

        @(negedge clk);
        check_eq("won.win_pulse", 32'(win), 0);
        check_eq("won.busy", 32'(busy), 1);
        btn_left = 1'b1;
        @(negedge clk);
        btn_left = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("won.req", 32'(mem_bus.mem_req), 0);
        check_eq("won.pos", 32'({player_row, player_col}), 32'({4'd14, 4'd14}));
        check_eq("won.busy2", 32'(busy), 1);
        pulse_restart();
        check_eq("won_restart.pos", 32'({player_row, player_col}), 0);
        check_eq("won_restart.busy", 32'(busy), 0);

        // Async reset while the request is outstanding.
        do_move("pre_rst", 4'b0001, 4'b0000, 0, 1'b1, 0, 1, 1'b0, 19);
        btn_down = 1'b1;
        @(negedge clk);
        btn_down = 1'b0;
        check_eq("arst.req_before", 32'(mem_bus.mem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst.req_async", 32'(mem_bus.mem_req), 0);
        check_eq("arst.busy_async", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("arst.busy", 32'(busy), 0);
        check_eq("arst.req", 32'(mem_bus.mem_req), 0);
        check_eq("arst.pos", 32'({player_row, player_col}), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/player_move_ctrl.md
PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

Interface
REQ-001 Parameters SHALL be: START_ROW, 0, reset row; START_COL, 0, reset column; GOAL_ROW, 14, goal row; GOAL_COL, 14, goal column; COOL_CYCLES, 16, post-move lockout cycles (>=1).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 btn_up, btn_down, btn_left, btn_right  input  1 each  single-cycle move request pulses, already debounced.
REQ-005 restart  input  1  synchronous pulse returning the player to start.
REQ-006 mem_req  output  1  request to the shared maze wall memory.
REQ-007 mem_gnt  input  1  grant from the memory arbiter.
REQ-008 mem_row, mem_col  output  4 each  cell address presented with mem_req.
REQ-009 mem_walls  input  4  wall nibble of addressed cell: bit3 N, bit2 E, bit1 S, bit0 W; valid the cycle after mem_gnt.
REQ-010 player_row, player_col  output  4 each  current player cell.
REQ-011 moved, blocked, win  output  1 each  single-cycle result pulses.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, REQ, READ, CHECK, COOL, WON.
REQ-014 IDLE: any btn pulse latched as direction; simultaneous pulses resolved up>down>left>right; next state REQ.
REQ-015 Buttons SHALL be ignored in every state except IDLE.
REQ-016 REQ: mem_req=1, mem_row/mem_col=player cell, both held stable until the cycle mem_gnt=1; then READ.
REQ-017 READ: mem_walls registered; mem_req=0; next CHECK.
REQ-018 CHECK: move blocked if the latched direction's wall bit is 1 or target is outside rows 0..14 / cols 0..14; blocked pulses, position unchanged.
REQ-019 CHECK, not blocked: position updated (N row-1, S row+1, W col-1, E col+1), moved pulses the same cycle the new position appears.
REQ-020 After CHECK: if new position equals (GOAL_ROW, GOAL_COL), win pulses one cycle and state WON; else COOL.
REQ-021 COOL: down-counter loaded with COOL_CYCLES-1; returns to IDLE after exactly COOL_CYCLES cycles.
REQ-022 WON: holds position, busy=1, ignores buttons until restart.
REQ-023 restart in any state: next cycle position=START, state IDLE, mem_req=0, counters cleared; restart overrides a simultaneous mem_gnt or button.
REQ-024 Button to moved/blocked latency SHALL be 3 cycles with mem_gnt asserted the cycle after mem_req rises.

Reset
REQ-025 rst_n low: state IDLE; player_row=START_ROW, player_col=START_COL; mem_req, moved, blocked, win, busy=0; mem_row/mem_col=START; cooldown counter 0.
REQ-026 Reset mid-transaction SHALL drop mem_req immediately (asynchronously) and discard the latched direction.

Configuration
REQ-027 MAZE_MOVE_COUNT_EN defined: additional output move_count [9:0], incremented on each moved pulse, saturating at 1023, cleared by reset and restart.
REQ-028 MAZE_MOVE_COUNT_EN undefined: move_count port and counter absent; all other behaviour identical.

Structure
REQ-029 Package maze_pkg SHALL hold MAZE_ROWS=15, MAZE_COLS=15, wall bit indices (WALL_N=3, WALL_E=2, WALL_S=1, WALL_W=0), direction enum and FSM state enum.
REQ-030 Single module, no sub-module; cooldown counter and direction decode inline.

Verification
REQ-031 Player (0,0), mem_walls=4'b1001, btn_right, mem_gnt one cycle after req -> moved at cycle 3, player (0,1), busy for 3+16 cycles.
REQ-032 Player (0,0), btn_up, mem_walls=4'b0000 -> blocked pulse (out of bounds), position unchanged.
REQ-033 Player (3,3), btn_down and btn_left same cycle, mem_walls=4'b0010 -> direction down chosen, blocked pulse.
REQ-034 mem_gnt withheld 10 cycles -> mem_req and mem_row/mem_col stable all 10 cycles, buttons during wait ignored.
REQ-035 Player (13,14), btn_down, mem_walls=4'b0100 -> moved, win pulse, WON; further buttons ignored; restart -> (0,0), IDLE.
REQ-036 rst_n low while in REQ -> mem_req 0 without a clock edge; after release, IDLE at START.
